// File: rtl/otp_auth_ctrl.sv
// One-time-password authentication controller: latches an OTP, collects keypad digits,
// compares them and drives timed unlock / expired / lockout indications.
module otp_auth_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int EXPIRE_CYCLES  = 1_500_000_000,
    parameter int HOLD_CYCLES    = 250_000_000,
    parameter int LOCKOUT_CYCLES = 500_000_000,
    localparam int CODE_W = NUM_DIGITS * DIGIT_W,
    localparam int CNT_W  = $clog2(NUM_DIGITS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] lfsr_code,
    input  logic              lfsr_latch,
    input  logic [DIGIT_W-1:0] user_digit,
    input  logic              user_latch,
    input  logic              user_clear,
    output logic [CODE_W-1:0] otp,
    output logic [CODE_W-1:0] user_otp_out,
    output logic [CNT_W-1:0]  digit_cnt,
    output logic [2:0]        wrng_atmpt,
    output logic              unlock,
    output logic              expired,
    output logic              reset_sys,
    output logic [2:0]        state
);

    // Handshake: lfsr_latch / user_latch / user_clear are single-cycle valid pulses with
    // no back-pressure; a pulse outside the state that consumes it is simply dropped.

    localparam int MAX_HE  = (HOLD_CYCLES > EXPIRE_CYCLES) ? HOLD_CYCLES : EXPIRE_CYCLES;
    localparam int MAX_CYC = (LOCKOUT_CYCLES > MAX_HE) ? LOCKOUT_CYCLES : MAX_HE;
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TIMER_W-1:0] EXP_LAST  = TIMER_W'(EXPIRE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]         MAX_ATT   = 3'(MAX_ATTEMPTS);
    localparam logic [CNT_W-1:0]   LAST_DIG  = CNT_W'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GEN      = 3'd1,
        S_ENTER    = 3'd2,
        S_CHECK    = 3'd3,
        S_UNLOCKED = 3'd4,
        S_EXPIRED  = 3'd5,
        S_LOCKOUT  = 3'd6
    } state_t;

    state_t               state_q;
    logic [TIMER_W-1:0]   timer;
    logic                 hold_done;

    assign state = state_q;

    // End of a timed indication state; everything is cleared as the FSM drops to IDLE.
    always_comb begin
        hold_done = 1'b0;
        case (state_q)
            S_UNLOCKED, S_EXPIRED: hold_done = (timer == HOLD_LAST);
            S_LOCKOUT:             hold_done = (timer == LOCK_LAST);
            default:               hold_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            timer        <= '0;
            otp          <= '0;
            user_otp_out <= '0;
            digit_cnt    <= '0;
            wrng_atmpt   <= '0;
            unlock       <= 1'b0;
            expired      <= 1'b0;
            reset_sys    <= 1'b0;
        end else if (hold_done || state_q == S_IDLE) begin
            state_q      <= (state_q == S_IDLE) ? S_GEN : S_IDLE;
            timer        <= '0;
            otp          <= '0;
            user_otp_out <= '0;
            digit_cnt    <= '0;
            wrng_atmpt   <= '0;
            unlock       <= 1'b0;
            expired      <= 1'b0;
            reset_sys    <= 1'b0;
        end else begin
            case (state_q)
                S_GEN: begin
                    if (lfsr_latch) begin
                        otp     <= lfsr_code;
                        timer   <= '0;
                        state_q <= S_ENTER;
                    end
                end

                S_ENTER: begin
                    if (timer >= EXP_LAST) begin
                        state_q <= S_EXPIRED;
                        expired <= 1'b1;
                        timer   <= '0;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                        if (user_clear) begin
                            user_otp_out <= '0;
                            digit_cnt    <= '0;
                        end else if (user_latch) begin
                            // Digit 0 lands in the most significant slot.
                            for (int i = 0; i < NUM_DIGITS; i++) begin
                                if (digit_cnt == CNT_W'(i))
                                    user_otp_out[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] <= user_digit;
                            end
                            digit_cnt <= digit_cnt + CNT_W'(1);
                            if (digit_cnt == LAST_DIG)
                                state_q <= S_CHECK;
                        end
                    end
                end

                S_CHECK: begin
                    if (timer < EXP_LAST)
                        timer <= timer + TIMER_W'(1);
                    if (user_otp_out == otp) begin
                        state_q <= S_UNLOCKED;
                        unlock  <= 1'b1;
                        timer   <= '0;
                    end else if (wrng_atmpt + 3'd1 == MAX_ATT) begin
                        wrng_atmpt <= wrng_atmpt + 3'd1;
                        state_q    <= S_LOCKOUT;
                        reset_sys  <= 1'b1;
                        timer      <= '0;
                    end else begin
                        // Expire timer keeps running across retries.
                        wrng_atmpt   <= wrng_atmpt + 3'd1;
                        user_otp_out <= '0;
                        digit_cnt    <= '0;
                        state_q      <= S_ENTER;
                    end
                end

                S_UNLOCKED, S_EXPIRED, S_LOCKOUT: begin
                    timer <= timer + TIMER_W'(1);
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otp_auth_ctrl.sv
// Directed bench for otp_auth_ctrl with short timer parameters and hand-computed expectations.
module tb_otp_auth_ctrl;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int CODE_W     = 16;
    localparam int CNT_W      = 3;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_GEN = 3'd1, ST_ENTER = 3'd2, ST_CHECK = 3'd3,
                           ST_UNLOCKED = 3'd4, ST_EXPIRED = 3'd5, ST_LOCKOUT = 3'd6;

    logic              clk;
    logic              reset;
    logic [CODE_W-1:0] lfsr_code;
    logic              lfsr_latch;
    logic [DIGIT_W-1:0] user_digit;
    logic              user_latch;
    logic              user_clear;
    logic [CODE_W-1:0] otp;
    logic [CODE_W-1:0] user_otp_out;
    logic [CNT_W-1:0]  digit_cnt;
    logic [2:0]        wrng_atmpt;
    logic              unlock;
    logic              expired;
    logic              reset_sys;
    logic [2:0]        state;

    int tests_run;
    int tests_failed;
    logic [2:0] exp_q[$];

    otp_auth_ctrl #(
        .NUM_DIGITS(NUM_DIGITS), .DIGIT_W(DIGIT_W), .MAX_ATTEMPTS(3),
        .EXPIRE_CYCLES(200), .HOLD_CYCLES(8), .LOCKOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .lfsr_code(lfsr_code), .lfsr_latch(lfsr_latch),
        .user_digit(user_digit), .user_latch(user_latch), .user_clear(user_clear),
        .otp(otp), .user_otp_out(user_otp_out), .digit_cnt(digit_cnt),
        .wrng_atmpt(wrng_atmpt), .unlock(unlock), .expired(expired),
        .reset_sys(reset_sys), .state(state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_otp"},   32'(otp), 32'h0);
        check({tag, "_buf"},   32'(user_otp_out), 32'h0);
        check({tag, "_cnt"},   32'(digit_cnt), 32'h0);
        check({tag, "_wrng"},  32'(wrng_atmpt), 32'h0);
        check({tag, "_flags"}, 32'({unlock, expired, reset_sys}), 32'h0);
        check({tag, "_state"}, 32'(state), 32'(ST_IDLE));
    endtask

    // Release reset at a falling edge, then expect IDLE followed by GEN.
    task automatic release_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        check({tag, "_idle"}, 32'(state), 32'(ST_IDLE));
        tick();
        check({tag, "_gen"}, 32'(state), 32'(ST_GEN));
    endtask

    task automatic latch_otp(input logic [CODE_W-1:0] code);
        lfsr_code  = code;
        lfsr_latch = 1'b1;
        tick();
        lfsr_latch = 1'b0;
        check("latch_state", 32'(state), 32'(ST_ENTER));
        check("latch_otp", 32'(otp), 32'(code));
    endtask

    task automatic key(input logic [DIGIT_W-1:0] d);
        user_digit = d;
        user_latch = 1'b1;
        tick();
        user_latch = 1'b0;
    endtask

    task automatic enter_code(input logic [CODE_W-1:0] code);
        key(code[15:12]);
        key(code[11:8]);
        key(code[7:4]);
        key(code[3:0]);
        check("check_state", 32'(state), 32'(ST_CHECK));
        check("check_cnt", 32'(digit_cnt), 32'd4);
        check("check_buf", 32'(user_otp_out), 32'(code));
        tick();
        check("post_check", 32'(state), 32'(exp_q.pop_front()));
    endtask

    // Count consecutive cycles a flag stays high (bounded), then expect IDLE and GEN.
    task automatic hold_len(input string tag, input int sel, input int exp_len);
        int n;
        logic f;
        n = 0;
        f = (sel == 0) ? unlock : (sel == 1) ? expired : reset_sys;
        while (f && n < 100) begin
            n++;
            tick();
            f = (sel == 0) ? unlock : (sel == 1) ? expired : reset_sys;
        end
        check({tag, "_len"}, 32'(n), 32'(exp_len));
        check_all_zero({tag, "_end"});
        tick();
        check({tag, "_gen"}, 32'(state), 32'(ST_GEN));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        lfsr_code    = '0;
        lfsr_latch   = 1'b0;
        user_digit   = '0;
        user_latch   = 1'b0;
        user_clear   = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        release_reset("rel0");

        // 1: correct entry
        latch_otp(16'h3A7C);
        exp_q.push_back(ST_UNLOCKED);
        enter_code(16'h3A7C);
        check("t1_unlock", 32'(unlock), 32'd1);
        hold_len("t1", 0, 8);

        // 2: one wrong entry then correct
        latch_otp(16'h1234);
        exp_q.push_back(ST_ENTER);
        enter_code(16'h1235);
        check("t2_wrng", 32'(wrng_atmpt), 32'd1);
        check("t2_cnt", 32'(digit_cnt), 32'd0);
        check("t2_buf", 32'(user_otp_out), 32'h0);
        exp_q.push_back(ST_UNLOCKED);
        enter_code(16'h1234);
        check("t2_unlock", 32'(unlock), 32'd1);
        check("t2_wrng_keep", 32'(wrng_atmpt), 32'd1);
        hold_len("t2", 0, 8);

        // 3: lockout after three failures
        latch_otp(16'h1234);
        exp_q.push_back(ST_ENTER);
        enter_code(16'h0000);
        exp_q.push_back(ST_ENTER);
        enter_code(16'h4321);
        check("t3_wrng2", 32'(wrng_atmpt), 32'd2);
        exp_q.push_back(ST_LOCKOUT);
        enter_code(16'h9999);
        check("t3_wrng3", 32'(wrng_atmpt), 32'd3);
        check("t3_rsys", 32'(reset_sys), 32'd1);
        hold_len("t3", 2, 16);

        // 4: expiry, latch on the expiry cycle is ignored
        latch_otp(16'h5678);
        repeat (199) tick();
        check("t4_pre", 32'(state), 32'(ST_ENTER));
        key(4'h9);
        check("t4_state", 32'(state), 32'(ST_EXPIRED));
        check("t4_cnt", 32'(digit_cnt), 32'd0);
        check("t4_exp", 32'(expired), 32'd1);
        hold_len("t4", 1, 8);

        // 5: clear, clear+latch, then correct entry
        latch_otp(16'h1234);
        key(4'h1);
        key(4'h2);
        check("t5_cnt2", 32'(digit_cnt), 32'd2);
        check("t5_buf2", 32'(user_otp_out), 32'h1200);
        user_clear = 1'b1;
        tick();
        user_clear = 1'b0;
        check("t5_clr_cnt", 32'(digit_cnt), 32'd0);
        check("t5_clr_buf", 32'(user_otp_out), 32'h0);
        key(4'h1);
        user_clear = 1'b1;
        user_digit = 4'h7;
        user_latch = 1'b1;
        tick();
        user_clear = 1'b0;
        user_latch = 1'b0;
        check("t5_both_cnt", 32'(digit_cnt), 32'd0);
        check("t5_both_buf", 32'(user_otp_out), 32'h0);
        exp_q.push_back(ST_UNLOCKED);
        enter_code(16'h1234);
        check("t5_unlock", 32'(unlock), 32'd1);

        // 6a: asynchronous reset while UNLOCKED (asserted away from the rising edge)
        #2 reset = 1'b0;
        #1 check_all_zero("t6a");
        release_reset("t6a_rel");

        // 6b: asynchronous reset mid-entry
        latch_otp(16'hBEEF);
        key(4'hB);
        key(4'hE);
        check("t6b_cnt", 32'(digit_cnt), 32'd2);
        #2 reset = 1'b0;
        #1 check_all_zero("t6b");
        release_reset("t6b_rel");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
